// File: rtl/odpc_pkg.sv
// Shared definitions for the ODPC redundancy controller.
// Provides default widths, the FSM state enumeration and the status codes.
package odpc_pkg;

  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_PE_TIMEOUT = 64;
  localparam int unsigned DEF_CNT_W      = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN_A = 3'd1,
    S_RUN_B = 3'd2,
    S_RUN_C = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  typedef logic [1:0] status_t;

  localparam status_t ST_CLEAN  = 2'b00;
  localparam status_t ST_CORR   = 2'b01;
  localparam status_t ST_UNCORR = 2'b10;
  localparam status_t ST_TMO    = 2'b11;

endpackage

// File: rtl/odpc_redundancy_ctrl_if.sv
// Bus bundle between the controller, the operand source, the PE and the
// result consumer.
//   master : controller side (drives in_ready, pe_start/pe_op, out_*)
//   slave  : environment side (drives in_valid/in_data, pe_done/pe_data/pe_msb, out_ready)
interface odpc_redundancy_ctrl_if
  import odpc_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  logic              pe_start;
  logic [DATA_W-1:0] pe_op;
  logic              pe_done;
  logic [DATA_W-1:0] pe_data;
  logic              pe_msb;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_msb;
  logic [1:0]        out_status;

  modport master (
    input  in_valid, in_data, pe_done, pe_data, pe_msb, out_ready,
    output in_ready, pe_start, pe_op, out_valid, out_data, out_msb, out_status
  );

  modport slave (
    output in_valid, in_data, pe_done, pe_data, pe_msb, out_ready,
    input  in_ready, pe_start, pe_op, out_valid, out_data, out_msb, out_status
  );

endinterface

// File: rtl/odpc_vote3.sv
// Combinational 3-way bitwise majority vote with pairwise match flags.
//   a, b, c : candidate words
//   maj_c   : bitwise majority of a, b, c
//   a_eq_b, c_eq_a, c_eq_b : exact-match flags
module odpc_vote3 #(
  parameter int unsigned W = 17
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] maj_c,
  output logic         a_eq_b,
  output logic         c_eq_a,
  output logic         c_eq_b
);

  assign maj_c  = (a & b) | (a & c) | (b & c);
  assign a_eq_b = (a == b);
  assign c_eq_a = (c == a);
  assign c_eq_b = (c == b);

endmodule

// File: rtl/odpc_redundancy_ctrl.sv
// Time-redundant execution controller: runs the PE twice per operand,
// compares, runs a third pass and votes on mismatch, aborts a pass that
// exceeds PE_TIMEOUT cycles, and delivers result + status downstream.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : operand in / PE control / result out (master modport)
//   err_count  : saturating count of delivered non-clean results
module odpc_redundancy_ctrl
  import odpc_pkg::*;
#(
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned PE_TIMEOUT = DEF_PE_TIMEOUT,
  parameter int unsigned CNT_W      = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  odpc_redundancy_ctrl_if.master     bus,
  output logic [CNT_W-1:0]           err_count
);

  localparam int unsigned WORD_W = DATA_W + 1;
  localparam int unsigned TMO_W  = $clog2(PE_TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pe_op_q, pe_op_d;
  logic                pe_start_q, pe_start_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_msb_q, out_msb_d;
  status_t             out_status_q, out_status_d;
  logic [WORD_W-1:0]   slot_a_q, slot_a_d;
  logic [WORD_W-1:0]   slot_b_q, slot_b_d;
  logic [WORD_W-1:0]   slot_c_q, slot_c_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CNT_W-1:0]    err_q, err_d;

  logic [WORD_W-1:0]   pe_word;
  logic [WORD_W-1:0]   vote_b;
  logic [WORD_W-1:0]   maj;
  logic                a_eq_b, c_eq_a, c_eq_b;
  logic                done_ok;
  logic                expired;

  assign pe_word = {bus.pe_msb, bus.pe_data};
  // pe_start is high only in the first cycle of a RUN state; done is ignored then.
  assign done_ok = bus.pe_done && !pe_start_q;
  assign expired = (tmo_q == TMO_W'(PE_TIMEOUT));
  // In RUN_B the live PE result stands in for slot B so the compare is same-cycle.
  assign vote_b  = (state_q == S_RUN_B) ? pe_word : slot_b_q;

  odpc_vote3 #(.W(WORD_W)) u_vote (
    .a      (slot_a_q),
    .b      (vote_b),
    .c      (pe_word),
    .maj_c  (maj),
    .a_eq_b (a_eq_b),
    .c_eq_a (c_eq_a),
    .c_eq_b (c_eq_b)
  );

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pe_op_q      <= '0;
      pe_start_q   <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_msb_q    <= 1'b0;
      out_status_q <= ST_CLEAN;
      slot_a_q     <= '0;
      slot_b_q     <= '0;
      slot_c_q     <= '0;
      tmo_q        <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      pe_op_q      <= pe_op_d;
      pe_start_q   <= pe_start_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_msb_q    <= out_msb_d;
      out_status_q <= out_status_d;
      slot_a_q     <= slot_a_d;
      slot_b_q     <= slot_b_d;
      slot_c_q     <= slot_c_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    pe_op_d      = pe_op_q;
    pe_start_d   = 1'b0;
    in_ready_d   = in_ready_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_msb_d    = out_msb_q;
    out_status_d = out_status_q;
    slot_a_d     = slot_a_q;
    slot_b_d     = slot_b_q;
    slot_c_d     = slot_c_q;
    tmo_d        = tmo_q;
    err_d        = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          pe_op_d    = bus.in_data;
          pe_start_d = 1'b1;
          in_ready_d = 1'b0;
          tmo_d      = '0;
          state_d    = S_RUN_A;
        end
      end

      S_RUN_A, S_RUN_B, S_RUN_C: begin
        tmo_d = TMO_W'(tmo_q + 1'b1);
        if (done_ok) begin
          tmo_d = '0;
          if (state_q == S_RUN_A) begin
            slot_a_d   = pe_word;
            pe_start_d = 1'b1;
            state_d    = S_RUN_B;
          end else if (state_q == S_RUN_B) begin
            slot_b_d = pe_word;
            if (a_eq_b) begin
              out_data_d   = slot_a_q[DATA_W-1:0];
              out_msb_d    = slot_a_q[DATA_W];
              out_status_d = ST_CLEAN;
              out_valid_d  = 1'b1;
              state_d      = S_OUT;
            end else begin
              pe_start_d = 1'b1;
              state_d    = S_RUN_C;
            end
          end else begin
            slot_c_d     = pe_word;
            out_data_d   = maj[DATA_W-1:0];
            out_msb_d    = maj[DATA_W];
            out_status_d = (c_eq_a || c_eq_b) ? ST_CORR : ST_UNCORR;
            out_valid_d  = 1'b1;
            state_d      = S_OUT;
          end
        end else if (expired) begin
          out_data_d   = '0;
          out_msb_d    = 1'b0;
          out_status_d = ST_TMO;
          out_valid_d  = 1'b1;
          state_d      = S_OUT;
        end
      end

      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
          if ((out_status_q != ST_CLEAN) && (err_q != {CNT_W{1'b1}})) begin
            err_d = CNT_W'(err_q + 1'b1);
          end
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.pe_start   = pe_start_q;
  assign bus.pe_op      = pe_op_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_msb    = out_msb_q;
  assign bus.out_status = out_status_q;
  assign err_count      = err_q;

endmodule

// File: tb/tb_odpc_redundancy_ctrl.sv
// Scoreboard bench for odpc_redundancy_ctrl: directed jobs push expected
// results; a monitor pops and compares when out_valid is presented.
module tb_odpc_redundancy_ctrl;

  localparam int DW  = 16;
  localparam int TMO = 8;
  localparam int CW  = 2;

  typedef struct packed {
    logic [15:0] d;
    logic        m;
    logic [7:0]  dly;   // cycles from pe_start to pe_done; 0 = never respond
  } resp_t;

  typedef struct {
    logic [15:0] op;
    logic [15:0] d;
    logic        m;
    logic [1:0]  s;
    int          starts;
    int          lat;
    int          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [CW-1:0] err_count;

  odpc_redundancy_ctrl_if #(.DATA_W(DW)) bif ();

  odpc_redundancy_ctrl #(.DATA_W(DW), .PE_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bif),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    accept_cyc = 0;
  int    job_starts = 0;
  int    jobs_done = 0;
  int    exp_err = 0;
  resp_t pe_q[$];
  exp_t  sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic resp_t mk(input logic [15:0] d, input logic m, input logic [7:0] dly);
    resp_t r;
    r.d = d; r.m = m; r.dly = dly;
    return r;
  endfunction

  // PE model: one response per pe_start pulse, taken from pe_q.
  initial begin
    int    cnt = -1;
    resp_t cur;
    bif.pe_done = 1'b0;
    bif.pe_data = '0;
    bif.pe_msb  = 1'b0;
    forever begin
      @(negedge clk);
      bif.pe_done = 1'b0;
      if (!rst_n) begin
        cnt = -1;
        pe_q.delete();
      end else if (bif.pe_start) begin
        job_starts++;
        if (pe_q.size() == 0) begin
          total++; bad++;
          $display("FAIL pe_start_unexpected: got start with empty response table");
          cnt = -1;
        end else begin
          cur = pe_q.pop_front();
          cnt = (cur.dly == 0) ? -1 : int'(cur.dly);
        end
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bif.pe_done = 1'b1;
          bif.pe_data = cur.d;
          bif.pe_msb  = cur.m;
          cnt = -1;
        end
      end
    end
  end

  // Monitor: compare on first out_valid cycle, stability while held, err after handshake.
  initial begin
    logic        seen = 1'b0;
    logic        pend = 1'b0;
    logic        have = 1'b0;
    exp_t        e;
    logic [15:0] pd;
    logic        pm;
    logic [1:0]  ps;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (have) chk("err_count", 32'(err_count), 32'(e.err));
        pend = 1'b0;
        jobs_done++;
      end
      if (!rst_n) begin
        seen = 1'b0;
      end else if (bif.out_valid) begin
        chk("in_ready_busy", 32'(bif.in_ready), 32'd0);
        if (!seen) begin
          if (sb.size() == 0) begin
            total++; bad++; have = 1'b0;
            $display("FAIL out_unexpected: got out_valid=1 with no expected result");
          end else begin
            e = sb.pop_front(); have = 1'b1;
            chk("out_data", 32'(bif.out_data), 32'(e.d));
            chk("out_msb", 32'(bif.out_msb), 32'(e.m));
            chk("out_status", 32'(bif.out_status), 32'(e.s));
            chk("pe_starts", 32'(job_starts), 32'(e.starts));
            chk("pe_op", 32'(bif.pe_op), 32'(e.op));
            if (e.lat != 0) chk("latency", 32'(cyc - accept_cyc), 32'(e.lat));
          end
          seen = 1'b1;
          pd = bif.out_data; pm = bif.out_msb; ps = bif.out_status;
        end else begin
          chk("hold_data", 32'(bif.out_data), 32'(pd));
          chk("hold_msb", 32'(bif.out_msb), 32'(pm));
          chk("hold_status", 32'(bif.out_status), 32'(ps));
        end
        if (bif.out_ready) begin
          pend = 1'b1;
          seen = 1'b0;
        end
      end
    end
  end

  task automatic job(input logic [15:0] op, input resp_t r0, input resp_t r1, input resp_t r2,
                     input int nresp, input logic [15:0] ed, input logic em, input logic [1:0] es,
                     input int est, input int elat, input int hold);
    exp_t e;
    int   n;
    int   target;
    target = jobs_done + 1;
    if (nresp > 0) pe_q.push_back(r0);
    if (nresp > 1) pe_q.push_back(r1);
    if (nresp > 2) pe_q.push_back(r2);
    if (es != 2'b00 && exp_err < (1 << CW) - 1) exp_err++;
    e.op = op; e.d = ed; e.m = em; e.s = es; e.starts = est; e.lat = elat; e.err = exp_err;
    sb.push_back(e);
    if (hold > 0) bif.out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!bif.in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin total++; bad++; $display("FAIL in_ready_wait: got 0 expected 1"); end
    job_starts = 0;
    accept_cyc = cyc;
    bif.in_valid = 1'b1;
    bif.in_data  = op;
    @(negedge clk);
    bif.in_valid = 1'b0;
    bif.in_data  = 16'hDEAD;
    if (hold > 0) begin
      n = 0;
      while (!bif.out_valid && n < 200) begin @(negedge clk); n++; end
      repeat (hold) @(negedge clk);
      @(posedge clk);
      #1 bif.out_ready = 1'b1;
    end
    n = 0;
    while (jobs_done < target && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin total++; bad++; $display("FAIL job_done_wait: got timeout expected completion"); end
  endtask

  initial begin
    int    rises;
    resp_t nr;
    nr = mk(16'h0, 1'b0, 8'd0);
    bif.in_valid  = 1'b0;
    bif.in_data   = '0;
    bif.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("rst_pe_start", 32'(bif.pe_start), 32'd0);
    chk("rst_out_valid", 32'(bif.out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("post_rst_pe_op", 32'(bif.pe_op), 32'd0);
    chk("post_rst_out_data", 32'({bif.out_msb, bif.out_data}), 32'd0);
    chk("post_rst_status", 32'(bif.out_status), 32'd0);
    chk("post_rst_err", 32'(err_count), 32'd0);

    // clean, single upset, uncorrectable, timeout in RUN_B
    job(16'h1234, mk(16'h00AB, 0, 1), mk(16'h00AB, 0, 1), nr, 2, 16'h00AB, 0, 2'b00, 2, 5, 0);
    job(16'h2222, mk(16'h00AB, 0, 1), mk(16'h00AF, 0, 1), mk(16'h00AB, 0, 1), 3,
        16'h00AB, 0, 2'b01, 3, 7, 0);
    job(16'h3333, mk(16'h0001, 0, 1), mk(16'h0002, 0, 1), mk(16'h0004, 0, 1), 3,
        16'h0000, 0, 2'b10, 3, 7, 0);
    job(16'h4444, mk(16'h0055, 1, 1), nr, nr, 2, 16'h0000, 0, 2'b11, 2, 12, 0);
    // done exactly on the expiry cycle wins; one cycle later times out
    job(16'h5555, mk(16'h0077, 0, 1), mk(16'h0077, 0, 8), nr, 2, 16'h0077, 0, 2'b00, 2, 12, 0);
    job(16'h6666, mk(16'h0077, 0, 1), mk(16'h0077, 0, 9), nr, 2, 16'h0000, 0, 2'b11, 2, 12, 0);
    // backpressure: 10 cycles out_ready=0, msb set, 3-cycle PE
    job(16'h7777, mk(16'hBEEF, 1, 3), mk(16'hBEEF, 1, 3), nr, 2, 16'hBEEF, 1, 2'b00, 2, 9, 10);
    // msb-only upset corrected; err_count saturates at 3
    for (int i = 0; i < 4; i++) begin
      job(16'h0F00 + 16'(i), mk(16'h0F0F, 1, 1), mk(16'h0F0F, 0, 1), mk(16'h0F0F, 1, 2), 3,
          16'h0F0F, 1, 2'b01, 3, 8, 0);
    end

    // reset during RUN_B
    pe_q.push_back(mk(16'h0011, 0, 1));
    pe_q.push_back(mk(16'h0011, 0, 6));
    @(negedge clk);
    job_starts = 0;
    bif.in_valid = 1'b1;
    bif.in_data  = 16'h8888;
    @(negedge clk);
    bif.in_valid = 1'b0;
    begin
      int n = 0;
      while (job_starts < 2 && n < 50) begin @(negedge clk); n++; end
      chk("reach_run_b", 32'(job_starts), 32'd2);
    end
    @(negedge clk);
    rst_n = 1'b0;
    exp_err = 0;
    #1;
    chk("midrst_in_ready", 32'(bif.in_ready), 32'd1);
    chk("midrst_err", 32'(err_count), 32'd0);
    chk("midrst_out_valid", 32'(bif.out_valid), 32'd0);
    chk("midrst_pe_op", 32'(bif.pe_op), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    repeat (20) begin @(negedge clk); if (bif.out_valid) rises++; end
    chk("midrst_no_output", 32'(rises), 32'd0);

    job(16'h9999, mk(16'h0123, 0, 1), mk(16'h0123, 0, 1), nr, 2, 16'h0123, 0, 2'b00, 2, 5, 0);
    job(16'hAAAA, mk(16'h00F0, 0, 1), mk(16'h00F1, 0, 1), mk(16'h00F1, 0, 1), 3,
        16'h00F1, 0, 2'b01, 3, 7, 0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
